// File: rtl/ram_secuenciador.sv
`default_nettype none
// ============================================================================
//  Module      : ram_secuenciador
//  Description : Loads three operand pairs, writes differences, sums and their
//                totals into a 32x32 level-write RAM, then streams words 0-7 out.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_secuenciador #(
    parameter int ANCHO     = 32,
    parameter int N_PARES   = 3,
    parameter int DIR_RESTA = 0,
    parameter int DIR_SUMA  = 3,
    parameter int DIR_OTROS = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic [ANCHO-1:0] op_a,
    input  logic [ANCHO-1:0] op_b,
    input  logic             op_val,
    output logic             op_rdy,
    output logic [4:0]       DirRam,
    output logic [ANCHO-1:0] DatosE,
    output logic             WE,
    input  logic [ANCHO-1:0] DatosS,
    output logic [ANCHO-1:0] dato_sal,
    output logic [2:0]       dir_sal,
    output logic             dato_val,
    input  logic             dato_rdy,
    output logic             ocupado,
    output logic             listo
);

    localparam int                 c_ancho_k   = $clog2(N_PARES);
    localparam logic [c_ancho_k-1:0] c_ult_par = c_ancho_k'(N_PARES - 1);
    localparam logic [2:0]         c_dir_resta = 3'(DIR_RESTA);
    localparam logic [2:0]         c_dir_suma  = 3'(DIR_SUMA);
    localparam logic [2:0]         c_dir_otros = 3'(DIR_OTROS);
    localparam logic [2:0]         c_dir_ult   = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CARGA   = 3'd1,
        ESCRIBE = 3'd2,
        LEE     = 3'd3,
        FIN     = 3'd4
    } estado_t;

    typedef enum logic [1:0] {
        SETUP  = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } fase_t;

    estado_t              r_estado_q, w_estado_d;
    fase_t                r_fase_q,   w_fase_d;
    logic [c_ancho_k-1:0] r_k_q,      w_k_d;
    logic [2:0]           r_dir_q,    w_dir_d;
    logic [ANCHO-1:0]     r_resta_q [N_PARES];
    logic [ANCHO-1:0]     w_resta_d [N_PARES];
    logic [ANCHO-1:0]     r_suma_q  [N_PARES];
    logic [ANCHO-1:0]     w_suma_d  [N_PARES];
    logic [2:0]           r_dir_ram_q,  w_dir_ram_d;
    logic [ANCHO-1:0]     r_datos_e_q,  w_datos_e_d;
    logic                 r_we_q,       w_we_d;
    logic                 r_op_rdy_q,   w_op_rdy_d;
    logic [ANCHO-1:0]     r_dato_sal_q, w_dato_sal_d;
    logic [2:0]           r_dir_sal_q,  w_dir_sal_d;
    logic                 r_dato_val_q, w_dato_val_d;
    logic                 r_ocupado_q,  w_ocupado_d;
    logic                 r_listo_q,    w_listo_d;

    logic [2:0]           w_dir_esc;
    logic [ANCHO-1:0]     w_dato_esc;
    logic [ANCHO-1:0]     w_total_resta;
    logic [ANCHO-1:0]     w_total_suma;

    // Address and data of the next SETUP: word 0 when leaving CARGA, else dir+1.
    always_comb begin
        w_total_resta = '0;
        w_total_suma  = '0;
        for (int i = 0; i < N_PARES; i++) begin
            w_total_resta = w_total_resta + r_resta_q[i];
            w_total_suma  = w_total_suma  + r_suma_q[i];
        end
        w_dir_esc = (r_estado_q == ESCRIBE) ? r_dir_q + 3'd1 : 3'd0;
        if (w_dir_esc < c_dir_suma) begin
            w_dato_esc = r_resta_q[c_ancho_k'(w_dir_esc - c_dir_resta)];
        end else if (w_dir_esc < c_dir_otros) begin
            w_dato_esc = r_suma_q[c_ancho_k'(w_dir_esc - c_dir_suma)];
        end else if (w_dir_esc == c_dir_otros) begin
            w_dato_esc = w_total_resta;
        end else begin
            w_dato_esc = w_total_suma;
        end
    end

    always_comb begin
        w_estado_d   = r_estado_q;
        w_fase_d     = r_fase_q;
        w_k_d        = r_k_q;
        w_dir_d      = r_dir_q;
        w_resta_d    = r_resta_q;
        w_suma_d     = r_suma_q;
        w_dir_ram_d  = r_dir_ram_q;
        w_datos_e_d  = r_datos_e_q;
        w_we_d       = 1'b0;
        w_op_rdy_d   = 1'b0;
        w_dato_sal_d = r_dato_sal_q;
        w_dir_sal_d  = r_dir_sal_q;
        w_dato_val_d = r_dato_val_q;
        w_ocupado_d  = 1'b1;
        w_listo_d    = 1'b0;

        unique case (r_estado_q)
            IDLE: begin
                w_ocupado_d = 1'b0;
                if (inicio) begin
                    w_estado_d  = CARGA;
                    w_op_rdy_d  = 1'b1;
                    w_ocupado_d = 1'b1;
                    w_k_d       = '0;
                end
            end
            CARGA: begin
                w_op_rdy_d = 1'b1;
                if (op_val && r_op_rdy_q) begin
                    w_resta_d[r_k_q] = op_a - op_b;
                    w_suma_d[r_k_q]  = op_a + op_b;
                    w_k_d            = r_k_q + 1'b1;
                    if (r_k_q == c_ult_par) begin
                        w_estado_d  = ESCRIBE;
                        w_op_rdy_d  = 1'b0;
                        w_k_d       = '0;
                        w_fase_d    = SETUP;
                        w_dir_d     = w_dir_esc;
                        w_dir_ram_d = w_dir_esc;
                        w_datos_e_d = w_dato_esc;
                    end
                end
            end
            ESCRIBE: begin
                unique case (r_fase_q)
                    SETUP: begin
                        w_we_d   = 1'b1;
                        w_fase_d = STROBE;
                    end
                    STROBE: w_fase_d = HOLD;
                    default: begin
                        if (r_dir_q == c_dir_ult) begin
                            w_estado_d  = LEE;
                            w_dir_d     = 3'd0;
                            w_dir_ram_d = 3'd0;
                        end else begin
                            w_fase_d    = SETUP;
                            w_dir_d     = w_dir_esc;
                            w_dir_ram_d = w_dir_esc;
                            w_datos_e_d = w_dato_esc;
                        end
                    end
                endcase
            end
            LEE: begin
                if (!r_dato_val_q) begin
                    w_dato_sal_d = DatosS;
                    w_dir_sal_d  = r_dir_q;
                    w_dato_val_d = 1'b1;
                end else if (dato_rdy) begin
                    // Wraps to 0 after word 7 so the RAM never sees address 8.
                    w_dato_val_d = 1'b0;
                    w_dir_d      = r_dir_q + 3'd1;
                    w_dir_ram_d  = r_dir_q + 3'd1;
                    if (r_dir_q == c_dir_ult) begin
                        w_estado_d = FIN;
                        w_listo_d  = 1'b1;
                    end
                end
            end
            FIN: begin
                w_estado_d  = IDLE;
                w_ocupado_d = 1'b0;
            end
            default: begin
                w_estado_d  = IDLE;
                w_ocupado_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado_q   <= IDLE;
            r_fase_q     <= SETUP;
            r_k_q        <= '0;
            r_dir_q      <= '0;
            r_resta_q    <= '{default: '0};
            r_suma_q     <= '{default: '0};
            r_dir_ram_q  <= '0;
            r_datos_e_q  <= '0;
            r_we_q       <= 1'b0;
            r_op_rdy_q   <= 1'b0;
            r_dato_sal_q <= '0;
            r_dir_sal_q  <= '0;
            r_dato_val_q <= 1'b0;
            r_ocupado_q  <= 1'b0;
            r_listo_q    <= 1'b0;
        end else begin
            r_estado_q   <= w_estado_d;
            r_fase_q     <= w_fase_d;
            r_k_q        <= w_k_d;
            r_dir_q      <= w_dir_d;
            r_resta_q    <= w_resta_d;
            r_suma_q     <= w_suma_d;
            r_dir_ram_q  <= w_dir_ram_d;
            r_datos_e_q  <= w_datos_e_d;
            r_we_q       <= w_we_d;
            r_op_rdy_q   <= w_op_rdy_d;
            r_dato_sal_q <= w_dato_sal_d;
            r_dir_sal_q  <= w_dir_sal_d;
            r_dato_val_q <= w_dato_val_d;
            r_ocupado_q  <= w_ocupado_d;
            r_listo_q    <= w_listo_d;
        end
    end

    assign DirRam   = {2'b00, r_dir_ram_q};
    assign DatosE   = r_datos_e_q;
    assign WE       = r_we_q;
    assign op_rdy   = r_op_rdy_q;
    assign dato_sal = r_dato_sal_q;
    assign dir_sal  = r_dir_sal_q;
    assign dato_val = r_dato_val_q;
    assign ocupado  = r_ocupado_q;
    assign listo    = r_listo_q;

endmodule
`default_nettype wire

// File: doc/ram_secuenciador.md
Name: ram_secuenciador

Overview:
Sequential initiator for the 32x32 combinational-write data RAM (ports DirRam, DatosE, WE, DatosS). Accepts three operand pairs over a valid/ready handshake, computes differences and sums, and writes them into the RAM regions: resta at 0-2, suma at 3-5, otros at 6-7. It then reads all eight words back and streams them out over a second valid/ready handshake. The block is the sole driver of the RAM address, data and write-enable.

Parameters:
ANCHO, 32, data width of operands, RAM words and results.
N_PARES, 3, operand pairs per run. Fixed at 3 to match the RAM region map.
DIR_RESTA, 0, first RAM address of the resta region.
DIR_SUMA, 3, first RAM address of the suma region.
DIR_OTROS, 6, first RAM address of the otros region (two words).

Ports:
clk  in  1  single clock, all state changes on rising edge
rst_n  in  1  synchronous active-low reset
inicio  in  1  start pulse, sampled only in IDLE
op_a  in  ANCHO  operand A
op_b  in  ANCHO  operand B
op_val  in  1  operand pair valid
op_rdy  out  1  block ready for an operand pair
DirRam  out  5  RAM address
DatosE  out  ANCHO  RAM write data
WE  out  1  RAM write enable (level-sensitive on the RAM side)
DatosS  in  ANCHO  RAM read data, combinational from DirRam
dato_sal  out  ANCHO  read-back word
dir_sal  out  3  RAM address of dato_sal (0-7)
dato_val  out  1  dato_sal valid
dato_rdy  in  1  downstream accepts dato_sal
ocupado  out  1  high in every state except IDLE
listo  out  1  one-cycle pulse when a run completes

Behaviour:
- Reset: the clock and reset arrangement is already decided as one clock (clk) with a synchronous, active-low reset (rst_n). rst_n low at a rising edge forces:
  - state IDLE
  - WE=0, DirRam=0, DatosE=0
  - op_rdy=0, dato_val=0, dato_sal=0, dir_sal=0
  - ocupado=0, listo=0
  - pair counter and result registers cleared
  Reset mid-run aborts immediately. WE falls at that edge. Partially written RAM contents are left as they are.
- All outputs are registered.
- States: IDLE -> CARGA -> ESCRIBE -> LEE -> FIN -> IDLE.
- IDLE:
  - inicio=1 -> CARGA.
  - inicio is ignored in every other state.
- CARGA:
  - op_rdy=1.
  - A pair transfers on an edge with op_val=1 and op_rdy=1. It is stored as pair k (k = 0..2).
  - resta[k] = A-B and suma[k] = A+B, both mod 2^ANCHO (wrap, no flags).
  - op_rdy drops on the edge that accepts the third pair -> ESCRIBE.
  - op_val with op_rdy=0 is ignored.
- ESCRIBE: eight writes in address order 0..7. Each write takes 3 cycles:
  - SETUP: DirRam and DatosE take new values, WE=0.
  - STROBE: WE=1, address and data unchanged.
  - HOLD: WE=0, address and data unchanged.
  - DirRam and DatosE never change in the same cycle WE changes.
  - Data written:
    - addr 0-2 = resta[0..2]
    - addr 3-5 = suma[0..2]
    - addr 6 = resta[0]+resta[1]+resta[2] (mod 2^ANCHO)
    - addr 7 = suma[0]+suma[1]+suma[2] (mod 2^ANCHO)
  - The phase lasts exactly 24 cycles. The first SETUP is the cycle after the third pair is accepted.
  - After the HOLD of addr 7 -> LEE.
- LEE: WE held 0. Per address i = 0..7:
  - Drive DirRam=i for one cycle.
  - On the next edge, register DatosS into dato_sal, set dir_sal=i and dato_val=1.
  - Hold dato_sal and dir_sal stable while dato_val=1 and dato_rdy=0.
  - When dato_val=1 and dato_rdy=1: dato_val=0 at the next edge and DirRam=i+1.
  - Minimum 2 cycles per word.
  - After word 7 is accepted -> FIN.
- FIN: listo=1 for exactly one cycle, ocupado=1 -> IDLE.
- Upper address bits DirRam[4:3] are always 0. Addresses 8-31 are never accessed.

Test Plan:
- Basic run: reset, inicio, pairs (10,3), (0,1), (0xFFFFFFFF,1) -> RAM[0..7] = 7, 0xFFFFFFFF, 0xFFFFFFFE, 13, 1, 0, 4, 14. Stream out the same eight words with dir_sal 0..7. listo pulses once.
- Write timing: monitor the RAM interface during ESCRIBE -> exactly 8 WE pulses, each 1 cycle wide, 24 cycles total. DirRam and DatosE are stable one cycle before and one cycle after each WE pulse.
- Backpressure: operands held with gaps (op_val toggling), and dato_rdy low for 5 cycles on word 3 -> no pair lost or duplicated. dato_sal and dir_sal stay constant while stalled. Final stream is unchanged from the basic run.
- Spurious inputs: inicio pulsed during CARGA and LEE, op_val=1 during ESCRIBE -> no state change, no extra RAM writes.
- Reset mid-operation: rst_n low during the STROBE of addr 4 -> WE=0 and all outputs at reset values on that edge, state IDLE. A new run with pairs (1,1), (2,1), (5,2) yields RAM[0..7] = 0, 1, 3, 2, 3, 7, 4, 12.
- Back-to-back runs: inicio on the cycle after listo -> second run starts. ocupado stays 0 only during the IDLE cycle.
